// File: rtl/modinv_pkg.sv
// Shared definitions for the modular-inverse front end: operand width, mode
// encodings, FSM state encoding and the buffered operand record.
package modinv_pkg;

    localparam int MODINV_W = 9;

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_INV  = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_GAP   = 2'd3;

    typedef struct packed {
        logic                mode;
        logic [MODINV_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/modinv_fifo.sv
// Synchronous FIFO of {mode, data} operands with an exact occupancy count,
// so full and empty are both decoded directly from the count.
module modinv_fifo
    import modinv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wrPtr_q] <= push_data_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem[rdPtr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/modinv_feeder.sv
// Operand sequencer in front of the modular-inverse unit: buffers operands and
// issues one at a time, waiting for completion. Watchdog: MODINV_FEEDER_TIMEOUT_EN.
module modinv_feeder
    import modinv_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 127
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [MODINV_W-1:0]   s_data,
    input  logic                  s_mode,
    output logic                  inv_in_valid,
    output logic [MODINV_W-1:0]   inv_data,
    output logic                  inv_mode,
    input  logic                  inv_done,
    output logic                  busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                  zero_drop,
    output logic                  err_timeout
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("modinv_feeder: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT < 8 || TIMEOUT > 255) begin : gBadTimeout
        $error("modinv_feeder: TIMEOUT must be in 8..255");
    end

    entry_t head;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;

    state_t               state_q,    state_d;
    logic                 inValid_q,  inValid_d;
    logic [MODINV_W-1:0]  invData_q,  invData_d;
    logic                 invMode_q,  invMode_d;
    logic                 busy_q,     busy_d;
    logic                 zeroDrop_q, zeroDrop_d;

    assign push = s_valid && !full;
    assign pop  = (state_q == ST_IDLE) && !empty;

    modinv_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({s_mode, s_data}),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (fifo_count)
    );

`ifdef MODINV_FEEDER_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wdog_q,       wdog_d;
    logic       errTimeout_q, errTimeout_d;
`endif

    // Every head of the FIFO is consumed in IDLE; a zero in inverse mode has
    // no inverse, so it is dropped there instead of being issued.
    always_comb begin
        state_d    = state_q;
        inValid_d  = 1'b0;
        invData_d  = invData_q;
        invMode_d  = invMode_q;
        zeroDrop_d = 1'b0;
`ifdef MODINV_FEEDER_TIMEOUT_EN
        wdog_d       = wdog_q;
        errTimeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (head.mode == MODE_INV && head.data == '0) begin
                        zeroDrop_d = 1'b1;
                    end else begin
                        invData_d = head.data;
                        invMode_d = head.mode;
                        inValid_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef MODINV_FEEDER_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            ST_WAIT: begin
                if (inv_done) begin
                    state_d = ST_GAP;
                end
`ifdef MODINV_FEEDER_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    errTimeout_d = 1'b1;
                    state_d      = ST_GAP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            inValid_q  <= 1'b0;
            invData_q  <= '0;
            invMode_q  <= MODE_PASS;
            busy_q     <= 1'b0;
            zeroDrop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inValid_q  <= inValid_d;
            invData_q  <= invData_d;
            invMode_q  <= invMode_d;
            busy_q     <= busy_d;
            zeroDrop_q <= zeroDrop_d;
        end
    end

`ifdef MODINV_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q       <= '0;
            errTimeout_q <= 1'b0;
        end else begin
            wdog_q       <= wdog_d;
            errTimeout_q <= errTimeout_d;
        end
    end

    assign err_timeout = errTimeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign s_ready      = !full;
    assign inv_in_valid = inValid_q;
    assign inv_data     = invData_q;
    assign inv_mode     = invMode_q;
    assign busy         = busy_q;
    assign zero_drop    = zeroDrop_q;

endmodule
